// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hazard controller.
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MC    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    localparam int CNT_W       = 5;
    localparam int STALL_W     = 5;
    localparam int STALL_CNT_W = 16;

    // Stall vectors are prefix-shaped; the bubble is inserted one stage past the top held bit.
    localparam logic [STALL_W-1:0] STALL_NONE = 5'b00000;
    localparam logic [STALL_W-1:0] STALL_ID   = 5'b00011;
    localparam logic [STALL_W-1:0] STALL_EX   = 5'b00111;

    localparam int STG_PC     = 0;
    localparam int STG_IF_ID  = 1;
    localparam int STG_ID_EX  = 2;
    localparam int STG_EX_MEM = 3;
    localparam int STG_MEM_WB = 4;

endpackage

// File: rtl/pipe_ctrl_cnt.sv
// Load/decrement/clear counter tracking remaining multi-cycle hold cycles.
module pipe_ctrl_cnt
    import pipe_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             clr,
    input  logic             dec,
    output logic [CNT_W-1:0] cnt,
    output logic             last
);

    logic [CNT_W-1:0] cnt_reg;

    // Clear wins over load so a flush in the same cycle as a start leaves nothing pending.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else if (clr) begin
            cnt_reg <= '0;
        end else if (load) begin
            cnt_reg <= load_val;
        end else if (dec && (cnt_reg != '0)) begin
            cnt_reg <= cnt_reg - 1'b1;
        end
    end

    assign cnt  = cnt_reg;
    assign last = (cnt_reg == {{(CNT_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stalls, multi-cycle EX holds and flush/redirect.
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   stallreq_id,
    input  logic                   ex_mc_start,
    input  logic [CNT_W-1:0]       ex_mc_cycles,
    input  logic                   ex_mc_done,
    input  logic                   flush_req,
    input  logic [31:0]            flush_pc,
    output logic [STALL_W-1:0]     stall_o,
    output logic                   flush_o,
    output logic [31:0]            new_pc_o,
    output logic                   mc_busy_o,
    output logic [STALL_CNT_W-1:0] stall_cnt_o
);

    state_t                 state_reg;
    state_t                 state_next;
    logic [STALL_W-1:0]     stall_next;
    logic                   flush_reg;
    logic [31:0]            new_pc_reg;
    logic                   busy_reg;
    logic [STALL_CNT_W-1:0] stall_cnt_reg;

    logic                   cnt_load;
    logic                   cnt_clr;
    logic                   cnt_dec;
    logic                   cnt_last;
    logic [CNT_W-1:0]       cnt_val;
    logic                   capture_pc;

    pipe_ctrl_cnt u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (ex_mc_cycles - 5'd1),
        .clr      (cnt_clr),
        .dec      (cnt_dec),
        .cnt      (cnt_val),
        .last     (cnt_last)
    );

    always_comb begin
        state_next = state_reg;
        stall_next = STALL_NONE;
        cnt_load   = 1'b0;
        cnt_clr    = 1'b0;
        cnt_dec    = 1'b0;
        capture_pc = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (flush_req) begin
                    cnt_clr    = 1'b1;
                    capture_pc = 1'b1;
                    state_next = ST_FLUSH;
                end else if (ex_mc_start && (ex_mc_cycles != '0)) begin
                    stall_next = STALL_EX;
                    // A single-cycle op is fully covered by this cycle's hold.
                    if (ex_mc_cycles >= 5'd2) begin
                        cnt_load   = 1'b1;
                        state_next = ST_MC;
                    end
                end else if (stallreq_id) begin
                    stall_next = STALL_ID;
                end
            end
            ST_MC: begin
                if (flush_req) begin
                    cnt_clr    = 1'b1;
                    capture_pc = 1'b1;
                    state_next = ST_FLUSH;
                end else if (ex_mc_done) begin
                    cnt_clr    = 1'b1;
                    state_next = ST_IDLE;
                end else begin
                    stall_next = STALL_EX;
                    cnt_dec    = 1'b1;
                    if (cnt_last || (cnt_val == '0)) begin
                        state_next = ST_IDLE;
                    end
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    capture_pc = 1'b1;
                    state_next = ST_FLUSH;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                cnt_clr    = 1'b1;
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg  <= ST_IDLE;
            flush_reg  <= 1'b0;
            new_pc_reg <= 32'h0;
            busy_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            flush_reg <= (state_next == ST_FLUSH);
            busy_reg  <= (state_next == ST_MC);
            if (capture_pc) begin
                new_pc_reg <= flush_pc;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_reg <= '0;
        end else if (stall_o[STG_PC] && (stall_cnt_reg != {STALL_CNT_W{1'b1}})) begin
            stall_cnt_reg <= stall_cnt_reg + 1'b1;
        end
    end

    // Reset gating keeps the hold vector quiet even while inputs are still toggling.
    assign stall_o     = rst ? stall_next : STALL_NONE;
    assign flush_o     = flush_reg;
    assign new_pc_o    = new_pc_reg;
    assign mc_busy_o   = busy_reg;
    assign stall_cnt_o = stall_cnt_reg;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl with hand-computed expectations.
module tb_pipe_ctrl;

    logic        clk;
    logic        rst;
    logic        stallreq_id;
    logic        ex_mc_start;
    logic [4:0]  ex_mc_cycles;
    logic        ex_mc_done;
    logic        flush_req;
    logic [31:0] flush_pc;
    logic [4:0]  stall_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        mc_busy_o;
    logic [15:0] stall_cnt_o;

    int n_checks = 0;
    int n_pass   = 0;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stallreq_id  (stallreq_id),
        .ex_mc_start  (ex_mc_start),
        .ex_mc_cycles (ex_mc_cycles),
        .ex_mc_done   (ex_mc_done),
        .flush_req    (flush_req),
        .flush_pc     (flush_pc),
        .stall_o      (stall_o),
        .flush_o      (flush_o),
        .new_pc_o     (new_pc_o),
        .mc_busy_o    (mc_busy_o),
        .stall_cnt_o  (stall_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got %h, expected %h", tag, obs, exp);
        end else begin
            n_pass++;
            $display("ok   %s = %h", tag, obs);
        end
    endtask

    // Apply one cycle's inputs at the falling edge; outputs are sampled 1 ns later.
    task automatic cyc(input logic sreq, input logic start, input logic [4:0] n,
                       input logic done, input logic fl, input logic [31:0] pc);
        @(negedge clk);
        stallreq_id  = sreq;
        ex_mc_start  = start;
        ex_mc_cycles = n;
        ex_mc_done   = done;
        flush_req    = fl;
        flush_pc     = pc;
        #1;
    endtask

    task automatic idle();
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
    endtask

    initial begin
        rst = 1'b0;
        stallreq_id = 1'b1; ex_mc_start = 1'b1; ex_mc_cycles = 5'd7;
        ex_mc_done = 1'b0; flush_req = 1'b1; flush_pc = 32'hDEADBEEF;
        @(negedge clk); @(negedge clk); #1;
        check("rst_stall", {27'd0, stall_o}, 32'h0);
        check("rst_flush", {31'd0, flush_o}, 32'h0);
        check("rst_newpc", new_pc_o, 32'h0);
        check("rst_busy", {31'd0, mc_busy_o}, 32'h0);
        check("rst_cnt", {16'd0, stall_cnt_o}, 32'h0);
        @(negedge clk);
        stallreq_id = 1'b0; ex_mc_start = 1'b0; flush_req = 1'b0;
        rst = 1'b1;

        // load-use stall
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("lu_stall", {27'd0, stall_o}, 32'h03);
        idle();
        check("lu_after", {27'd0, stall_o}, 32'h00);
        check("lu_cnt", {16'd0, stall_cnt_o}, 32'd1);

        // full multi-cycle op, N=5
        cyc(1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 32'h0);
        check("mc5_c0_stall", {27'd0, stall_o}, 32'h07);
        check("mc5_c0_busy", {31'd0, mc_busy_o}, 32'h0);
        for (int i = 1; i <= 4; i++) begin
            idle();
            check($sformatf("mc5_c%0d_stall", i), {27'd0, stall_o}, 32'h07);
            check($sformatf("mc5_c%0d_busy", i), {31'd0, mc_busy_o}, 32'h1);
        end
        idle();
        check("mc5_end_stall", {27'd0, stall_o}, 32'h00);
        check("mc5_end_busy", {31'd0, mc_busy_o}, 32'h0);
        check("mc5_cnt", {16'd0, stall_cnt_o}, 32'd6);

        // early completion, N=10, done on third MC cycle
        cyc(1'b0, 1'b1, 5'd10, 1'b0, 1'b0, 32'h0);
        check("ec_c0_stall", {27'd0, stall_o}, 32'h07);
        idle();
        check("ec_c1_stall", {27'd0, stall_o}, 32'h07);
        cyc(1'b0, 1'b1, 5'd3, 1'b0, 1'b0, 32'h0);
        check("ec_c2_stall", {27'd0, stall_o}, 32'h07);
        cyc(1'b0, 1'b0, 5'd0, 1'b1, 1'b0, 32'h0);
        check("ec_done_stall", {27'd0, stall_o}, 32'h00);
        check("ec_done_busy", {31'd0, mc_busy_o}, 32'h1);
        idle();
        check("ec_idle_busy", {31'd0, mc_busy_o}, 32'h0);
        check("ec_idle_stall", {27'd0, stall_o}, 32'h00);
        check("ec_cnt", {16'd0, stall_cnt_o}, 32'd9);

        // N=1, N=0 with load-use, N=0 alone
        cyc(1'b0, 1'b1, 5'd1, 1'b0, 1'b0, 32'h0);
        check("n1_stall", {27'd0, stall_o}, 32'h07);
        idle();
        check("n1_after_stall", {27'd0, stall_o}, 32'h00);
        check("n1_after_busy", {31'd0, mc_busy_o}, 32'h0);
        cyc(1'b1, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0);
        check("n0_lu_stall", {27'd0, stall_o}, 32'h03);
        cyc(1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 32'h0);
        check("n0_stall", {27'd0, stall_o}, 32'h00);
        cyc(1'b1, 1'b1, 5'd4, 1'b0, 1'b0, 32'h0);
        check("both_stall", {27'd0, stall_o}, 32'h07);
        idle(); idle(); idle();
        idle();
        check("both_end_stall", {27'd0, stall_o}, 32'h00);
        check("both_cnt", {16'd0, stall_cnt_o}, 32'd15);

        // flush during MC
        cyc(1'b0, 1'b1, 5'd8, 1'b0, 1'b0, 32'h0);
        idle();
        check("fm_mc_stall", {27'd0, stall_o}, 32'h07);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b1, 32'hBFC00380);
        check("fm_req_stall", {27'd0, stall_o}, 32'h00);
        check("fm_req_flush", {31'd0, flush_o}, 32'h0);
        cyc(1'b1, 1'b1, 5'd6, 1'b1, 1'b0, 32'h0);
        check("fm_flush", {31'd0, flush_o}, 32'h1);
        check("fm_newpc", new_pc_o, 32'hBFC00380);
        check("fm_fl_stall", {27'd0, stall_o}, 32'h00);
        check("fm_fl_busy", {31'd0, mc_busy_o}, 32'h0);
        cyc(1'b1, 1'b0, 5'd0, 1'b0, 1'b0, 32'h0);
        check("fm_idle_flush", {31'd0, flush_o}, 32'h0);
        check("fm_idle_newpc", new_pc_o, 32'hBFC00380);
        check("fm_idle_stall", {27'd0, stall_o}, 32'h03);
        check("fm_idle_busy", {31'd0, mc_busy_o}, 32'h0);

        // back-to-back flush
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h100);
        cyc(1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 32'h200);
        check("bb1_flush", {31'd0, flush_o}, 32'h1);
        check("bb1_newpc", new_pc_o, 32'h100);
        idle();
        check("bb2_flush", {31'd0, flush_o}, 32'h1);
        check("bb2_newpc", new_pc_o, 32'h200);
        idle();
        check("bb3_flush", {31'd0, flush_o}, 32'h0);
        check("bb3_newpc", new_pc_o, 32'h200);

        // reset mid-MC, with a flush request pending as well
        cyc(1'b0, 1'b1, 5'd20, 1'b0, 1'b0, 32'h0);
        idle();
        check("rm_busy_pre", {31'd0, mc_busy_o}, 32'h1);
        rst = 1'b0;
        flush_req = 1'b1; flush_pc = 32'h1234;
        #1;
        check("rm_stall", {27'd0, stall_o}, 32'h00);
        check("rm_busy", {31'd0, mc_busy_o}, 32'h0);
        check("rm_cnt", {16'd0, stall_cnt_o}, 32'h0);
        check("rm_newpc", new_pc_o, 32'h0);
        check("rm_flush", {31'd0, flush_o}, 32'h0);
        @(negedge clk);
        flush_req = 1'b0;
        rst = 1'b1;
        idle();
        check("rm_rel_stall", {27'd0, stall_o}, 32'h00);
        check("rm_rel_busy", {31'd0, mc_busy_o}, 32'h0);
        check("rm_rel_flush", {31'd0, flush_o}, 32'h0);

        // saturation
        @(negedge clk);
        stallreq_id = 1'b1;
        repeat (70000) @(negedge clk);
        stallreq_id = 1'b0;
        #1;
        check("sat_cnt", {16'd0, stall_cnt_o}, 32'h0000FFFF);
        idle();
        check("sat_hold", {16'd0, stall_cnt_o}, 32'h0000FFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/pipe_ctrl.md
PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have one clock and an asynchronous, active-low reset.
REQ-002 SHALL expose `clk`  input  1  pipeline clock, rising edge.
REQ-003 SHALL expose `rst`  input  1  asynchronous active-low reset.
REQ-004 SHALL expose `stallreq_id`  input  1  level; ID-stage load-use hazard, one-cycle hold request.
REQ-005 SHALL expose `ex_mc_start`  input  1  single-cycle pulse; EX starts a multi-cycle op.
REQ-006 SHALL expose `ex_mc_cycles`  input  5  total hold cycles for that op (0..31), sampled with `ex_mc_start`.
REQ-007 SHALL expose `ex_mc_done`  input  1  pulse; EX reports early completion.
REQ-008 SHALL expose `flush_req`  input  1  pulse; exception or redirect.
REQ-009 SHALL expose `flush_pc`  input  32  redirect target, sampled with `flush_req`.
REQ-010 SHALL expose `stall_o`  output  5  hold per register: [0] pc, [1] if_id, [2] id_ex, [3] ex_mem, [4] mem_wb.
REQ-011 SHALL expose `flush_o`  output  1  registered; clears all pipeline registers.
REQ-012 SHALL expose `new_pc_o`  output  32  registered redirect PC, valid while `flush_o`=1.
REQ-013 SHALL expose `mc_busy_o`  output  1  high while in state MC.
REQ-014 SHALL expose `stall_cnt_o`  output  16  saturating count of cycles with `stall_o[0]`=1.

Function
REQ-015 SHALL implement a three-state FSM: IDLE, MC, FLUSH.
REQ-016 SHALL produce `stall_o` combinationally from state and current inputs, so the hold applies in the request cycle.
REQ-017 SHALL keep stall vectors prefix-shaped only: 00000, 00011 or 00111.
- The register downstream of the highest held bit inserts the bubble; that is outside this block.
REQ-018 SHALL resolve priority as `flush_req` > multi-cycle > `stallreq_id`.
REQ-019 IDLE behaviour SHALL be as follows.
- `stallreq_id` alone: `stall_o`=00011.
- `ex_mc_start` with N≥1: `stall_o`=00111 in the same cycle.
- Both together: `stall_o`=00111.
REQ-020 SHALL stay in IDLE when `ex_mc_start` arrives with N=0 or N=1; N=0 gives no MC hold.
REQ-021 SHALL, on `ex_mc_start` with N≥2, enter MC with internal counter = N-1, giving exactly N held cycles in total.
REQ-022 MC behaviour SHALL be as follows.
- Each cycle: `stall_o`=00111 and the counter decrements.
- Counter==1 in a cycle: return to IDLE in the next cycle.
- `ex_mc_start` is ignored while in MC.
REQ-023 SHALL, on `ex_mc_done` in MC, drive `stall_o`=00000 that cycle, clear the counter and return to IDLE.
REQ-024 SHALL, on `flush_req` in any state, do all of the following.
- Drive `stall_o`=00000 in that cycle.
- Abort MC and clear the counter.
- Capture `flush_pc` and enter FLUSH.
REQ-025 FLUSH SHALL last exactly one cycle.
- `flush_o`=1 and `new_pc_o`=captured PC; `stall_o`=00000.
- `stallreq_id`, `ex_mc_start` and `ex_mc_done` are ignored.
- Next state is IDLE.
REQ-026 SHALL, on `flush_req` during FLUSH, stay in FLUSH with the new PC captured (back-to-back flush).
REQ-027 SHALL make `flush_o` and `new_pc_o` registered outputs with 1-cycle latency from `flush_req`; `new_pc_o` holds its last value otherwise.
REQ-028 SHALL increment `stall_cnt_o` on each clock with `stall_o[0]`=1 and saturate at 16'hFFFF.

Reset
REQ-029 SHALL, on `rst`=0, immediately and asynchronously set the following.
- State=IDLE, counter=0.
- `flush_o`=0, `new_pc_o`=32'h0, `stall_cnt_o`=0, `mc_busy_o`=0.
REQ-030 SHALL drive `stall_o`=00000 throughout reset, irrespective of inputs.
REQ-031 SHALL abandon an in-flight MC or FLUSH on reset, with no flush pulse after deassertion.

Structure
REQ-032 SHALL place the following in shared package `pipe_pkg`.
- The FSM state typedef.
- Stall vector constants STALL_NONE=00000, STALL_ID=00011, STALL_EX=00111.
- Stage bit-index constants.
REQ-033 SHALL implement the 5-bit load/decrement/clear hold counter as sub-module `pipe_ctrl_cnt`.
- Ports: clk, rst, load, load_val, clr, dec, cnt, last.

Verification
REQ-034 SHALL cover a load-use stall: `stallreq_id`=1 for 1 cycle -> `stall_o`=00011 that cycle only; `stall_cnt_o`=1.
REQ-035 SHALL cover a full multi-cycle op: `ex_mc_start` with `ex_mc_cycles`=5 -> `stall_o`=00111 for exactly 5 cycles; `mc_busy_o` high for 4; then 00000.
REQ-036 SHALL cover early completion: `ex_mc_cycles`=10, `ex_mc_done` on the 3rd MC cycle -> `stall_o`=00000 that cycle; IDLE next.
REQ-037 SHALL cover flush during MC: MC active and `flush_req` with `flush_pc`=32'hBFC00380 -> same-cycle `stall_o`=00000; next cycle `flush_o`=1, `new_pc_o`=32'hBFC00380; then IDLE.
REQ-038 SHALL cover back-to-back flush: `flush_req` in consecutive cycles with PC 32'h100 then 32'h200 -> `flush_o` high for 2 cycles showing 32'h100 then 32'h200.
REQ-039 SHALL cover reset and saturation.
- `rst` low mid-MC -> all outputs zero asynchronously; no stall after release.
- 70000 stall cycles -> `stall_cnt_o`=16'hFFFF.
